// File: rtl/uart_tx_pacer_fifo.sv
// rtl/uart_tx_pacer_fifo.sv - byte FIFO that paces transmit-start pulses one frame apart
module uart_tx_pacer_fifo #(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = 4340
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             wr_data_i,
  input  logic                   wr_en_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_en_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(FRAME_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_WAIT
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, overflow_q;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic [TW-1:0] timer_q, timer_d;
  state_t        state_q, state_d;
  logic          pop, wr_ok;

  // Pacing FSM: a pop happens only from IDLE, so pulses are FRAME_CYCLES+1 apart.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          pop       = 1'b1;
          tx_en_d   = 1'b1;
          tx_data_d = mem[rd_ptr_q];
          timer_d   = TIMER_LOAD;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  // A full FIFO still takes a write when the same edge pops the head.
  assign wr_ok = wr_en_i && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      overflow_q <= wr_en_i && !wr_ok;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ok) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_en_o    = tx_en_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_pacer_fifo.sv
// tb/tb_uart_tx_pacer_fifo.sv - bench for uart_tx_pacer_fifo against a queue-based reference
module tb_uart_tx_pacer_fifo;

  localparam int DEPTH = 4;
  localparam int F     = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_en, full, empty, overflow;
  logic [$clog2(DEPTH):0] count;

  uart_tx_pacer_fifo #(.DEPTH(DEPTH), .FRAME_CYCLES(F)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_data_i  (wr_data),
    .wr_en_i    (wr_en),
    .tx_data_o  (tx_data),
    .tx_en_o    (tx_en),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference: byte queue plus earliest cycle a new pop is allowed.
  logic [7:0] q[$];
  int         next_ok = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_en = 1'b0;
  logic       m_ovf = 1'b0;

  logic [7:0] emitted[$];
  int         pulse_cyc[$];
  int         last_pulse = -1;
  int         ovf_cnt = 0;
  int         cnt_max = 0;
  bit         full_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [7:0] d);
    bit pop, acc, gap_ok;
    rst = r;
    wr_en = we;
    wr_data = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      next_ok = 0;
      m_data = 8'h00;
      m_en = 1'b0;
      m_ovf = 1'b0;
      last_pulse = -1;
    end else begin
      pop = (q.size() > 0) && (cyc >= next_ok);
      acc = we && ((q.size() < DEPTH) || pop);
      m_en = pop;
      if (pop) begin
        m_data = q.pop_front();
        next_ok = cyc + F + 1;
      end
      if (acc) q.push_back(d);
      m_ovf = we && !acc;
    end
    cyc++;
    #1;
    chk("tx_en", tx_en, m_en);
    chk("tx_data", tx_data, m_data);
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("overflow", overflow, m_ovf);
    if (tx_en === 1'b1) begin
      if (last_pulse >= 0) begin
        gap_ok = (cyc - last_pulse) >= F + 1;
        chk("spacing", gap_ok, 1);
      end
      last_pulse = cyc;
      emitted.push_back(tx_data);
      pulse_cyc.push_back(cyc);
    end
    if (overflow === 1'b1) ovf_cnt++;
    if (full === 1'b1) full_seen = 1;
    if (int'(count) > cnt_max) cnt_max = int'(count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_log();
    emitted.delete();
    pulse_cyc.delete();
    ovf_cnt = 0;
    cnt_max = 0;
    full_seen = 0;
  endtask

  initial begin
    int c0;
    int c1;
    logic [7:0] v;

    // 1: reset held 3 cycles, then 100 idle cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    clear_log();
    idle(100);
    chk("t1_no_pulse", pulse_cyc.size(), 0);

    // 2: single write, 2-cycle latency
    clear_log();
    c0 = cyc;
    step(1'b0, 1'b1, 8'h55);
    idle(40);
    chk("t2_npulse", pulse_cyc.size(), 1);
    chk("t2_latency", pulse_cyc[0] - c0, 2);
    chk("t2_byte", emitted[0], 8'h55);
    chk("t2_hold", tx_data, 8'h55);

    // 3: burst of three
    clear_log();
    c0 = cyc;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h41 + i));
    idle(60);
    chk("t3_npulse", pulse_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_cycle", pulse_cyc[i] - c0, 2 + 21 * i);
      chk("t3_byte", emitted[i], 8'(8'h41 + i));
    end
    chk("t3_peak", cnt_max, 2);

    // 4: overflow with six back-to-back writes
    clear_log();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(i + 1));
    idle(130);
    chk("t4_ovf_pulses", ovf_cnt, 1);
    chk("t4_full_seen", full_seen, 1);
    chk("t4_n", emitted.size(), 5);
    for (int i = 0; i < 5; i++) chk("t4_byte", emitted[i], 8'(i + 1));

    // 5: paced writes across pointer wrap
    clear_log();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'(8'hA0 + i));
      idle(24);
    end
    idle(10);
    chk("t5_n", emitted.size(), 8);
    for (int i = 0; i < 8; i++) chk("t5_byte", emitted[i], 8'(8'hA0 + i));
    chk("t5_full", full_seen, 0);
    chk("t5_ovf", ovf_cnt, 0);

    // 6: reset in the middle of WAIT
    clear_log();
    c0 = cyc;
    step(1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b1, 8'h20);
    while (cyc < c0 + 7) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(50);
    chk("t6_npulse", pulse_cyc.size(), 1);
    chk("t6_first", emitted[0], 8'h10);
    chk("t6_empty", empty, 1);
    clear_log();
    c1 = cyc;
    step(1'b0, 1'b1, 8'h30);
    idle(5);
    chk("t6_npost", pulse_cyc.size(), 1);
    chk("t6_post_lat", pulse_cyc[0] - c1, 2);
    chk("t6_post_byte", emitted[0], 8'h30);

    // Randomized traffic: alternating dense and sparse phases, rare resets
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit dense;
      bit rs;
      r = $urandom_range(0, 99);
      dense = ((i / 150) % 2) == 0;
      rs = ($urandom_range(0, 599) == 0);
      v = 8'($urandom);
      step(rs, dense ? (r < 70) : (r < 4), v);
    end
    idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_pacer_fifo.md
Name: uart_tx_pacer_fifo

Overview:
- Buffer and rate-pacing stage between the UART receive path and the UART transmit path in the loopback/echo design.
- Accepts single-cycle byte strobes (the receiver's data + done pulse), stores them in a synchronous FIFO and issues them to the transmitter as one-cycle enable pulses.
- Pulses are spaced at least one frame time apart, because the transmit path exposes no busy flag.
- Prevents bytes arriving back-to-back, or in bursts, from corrupting a frame in progress.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- FRAME_CYCLES, 4340, clk_i cycles reserved per transmitted frame (50 MHz / 115200 baud x 10 bits); must be >= 2.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- wr_data_i  input  8  byte to enqueue; sampled when wr_en_i = 1.
- wr_en_i  input  1  one-cycle write strobe; connects to the receiver done pulse.
- tx_data_o  output  8  byte presented to the transmit path; registered.
- tx_en_o  output  1  one-cycle transmit start pulse; registered.
- full_o  output  1  FIFO holds DEPTH bytes.
- empty_o  output  1  FIFO holds 0 bytes.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Clocking and reset: one clock domain (clk_i); reset is synchronous and active-high (rst_i).
- Reset values: tx_data_o=0, tx_en_o=0, full_o=0, empty_o=1, count_o=0, overflow_o=0. Read and write pointers are cleared, stored contents are discarded, the pacing timer is cleared and the state is IDLE.
- Reset while in WAIT aborts the wait with no further pulse. rst_i has priority over every other input in the same cycle.
- FIFO storage: circular buffer with wrapping pointers. full_o, empty_o and count_o are registered and update on the same edge as the pointers.
- Write rule: a write is accepted when wr_en_i=1 and either count_o<DEPTH, or a pop occurs on the same edge.
  - Accepted: the byte is stored at the write pointer and the write pointer increments.
  - Not accepted: the byte is dropped, overflow_o=1 for the following cycle, and contents, pointers and count are unchanged.
- Occupancy:
  - Simultaneous accepted write and pop: count unchanged.
  - Write only: count+1.
  - Pop only: count-1.
- Pacing FSM states:
  - IDLE: when count_o>0, on the next edge:
    - tx_data_o <= head byte, tx_en_o <= 1;
    - read pointer increments (pop), count decrements;
    - timer <= FRAME_CYCLES-1; state <= WAIT.
  - IDLE with count_o=0: remain in IDLE; tx_en_o stays 0.
  - WAIT: tx_en_o <= 0 on the first edge in WAIT. tx_data_o holds its value through the whole WAIT. The timer decrements each edge; on the edge where timer==0, state <= IDLE.
- Latency: with an empty FIFO, wr_en_i high in cycle 0 gives tx_en_o high in cycle 2, with tx_data_o equal to that byte in the same cycle.
- Spacing: consecutive tx_en_o pulses are exactly FRAME_CYCLES+1 cycles apart while the FIFO is non-empty, and never fewer.
- tx_en_o is never high for two consecutive cycles. tx_data_o changes only on an edge that also raises tx_en_o.
- Ordering: strict FIFO order, including across pointer wrap-around.
- Writing into an empty FIFO while in WAIT: the byte is held until the state returns to IDLE, then issued on the next edge.

Test Plan (bench uses DEPTH=4, FRAME_CYCLES=20):
1. Reset then idle, with rst_i held 3 cycles -> all outputs at reset values; no tx_en_o pulse over 100 idle cycles.
2. Single write 0x55 in cycle 0 -> tx_en_o high only in cycle 2 with tx_data_o=0x55; count_o returns to 0 in cycle 2; tx_data_o stays 0x55 afterwards.
3. Burst of writes 0x41,0x42,0x43 on consecutive cycles -> tx_en_o pulses at cycles 2, 23, 44 carrying 0x41, 0x42, 0x43; count_o peaks at 2.
4. Overflow: six back-to-back writes 0x01..0x06 -> the first pop at cycle 2 frees a slot, so 0x01..0x05 are accepted. 0x06 is dropped, full_o=1 and overflow_o pulses once. Output order is 0x01..0x05, with no 0x06.
5. Wrap-around: eight paced writes, one every 25 cycles, with values 0xA0..0xA7 -> all eight are emitted in order, full_o never asserts and overflow_o stays 0.
6. Reset mid-WAIT: write 0x10,0x20, then assert rst_i 5 cycles after the first tx_en_o -> 0x20 is never emitted, empty_o=1, and no tx_en_o until a new write; a post-reset write of 0x30 appears 2 cycles later.
